// File: rtl/irq_ctrl_if.sv
// CPU bus window into the interrupt controller.
// The CPU-side decoder drives the request; the controller returns combinational read data.
interface irq_ctrl_if;
  logic [31:0] addr;
  logic        sel;
  logic        we;
  logic [31:0] wdata;
  logic [31:0] rdata;

  modport master (
    output addr, sel, we, wdata,
    input  rdata
  );

  modport slave (
    input  addr, sel, we, wdata,
    output rdata
  );
endinterface

// File: rtl/irq_ctrl.sv
// Three-source interrupt controller with MASK/PEND/STAT registers and a request FSM.
// Define IRQ_EDGE_EN for rising-edge capture; otherwise sources are level-sensitive.
module irq_ctrl (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       irq_src,
  irq_ctrl_if.slave        bus,
  output logic             int_req,
  output logic [1:0]       int_id,
  input  logic             int_ack,
  input  logic             eret,
  output logic [5:0]       hwint
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    SVC  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] mask_q, mask_d;
  logic [2:0] pend_q, pend_d;
  logic [1:0] id_q, id_d;
  logic [2:0] set_v;
  logic [2:0] clr_v;
  logic [2:0] masked;
  logic [2:0] pend_sw;
  logic [3:0] keep4;
  logic [3:0] masked4;
  logic [3:0] ack4;
  logic [1:0] low_id;
  logic       wr_mask;
  logic       wr_pend;

`ifdef IRQ_EDGE_EN
  logic [2:0] prev_q;

  always_ff @(posedge clk) begin
    if (reset) prev_q <= '0;
    else       prev_q <= irq_src;
  end

  assign set_v = irq_src & ~prev_q;
`else
  assign set_v = irq_src;
`endif

  assign wr_mask = bus.sel & bus.we & (bus.addr[3:2] == 2'd0);
  assign wr_pend = bus.sel & bus.we & (bus.addr[3:2] == 2'd1);
  assign clr_v   = wr_pend ? bus.wdata[2:0] : 3'b000;
  assign mask_d  = wr_mask ? bus.wdata[2:0] : mask_q;

  assign masked  = pend_q & mask_q;
  assign masked4 = {1'b0, masked};
  // what the granted bit would look like after this edge, ignoring the ack
  assign pend_sw = (pend_q & ~clr_v) | set_v;
  assign keep4   = {1'b0, pend_sw & mask_d};

  always_comb begin
    low_id = 2'd0;
    if (masked[0])      low_id = 2'd0;
    else if (masked[1]) low_id = 2'd1;
    else if (masked[2]) low_id = 2'd2;
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    ack4    = '0;
    case (state_q)
      IDLE: begin
        if (|masked) begin
          state_d = REQ;
          id_d    = low_id;
        end
      end
      REQ: begin
        if (int_ack && masked4[id_q]) begin
          state_d   = SVC;
          ack4[id_q] = 1'b1;
        end else if (!keep4[id_q]) begin
          state_d = IDLE;
        end
      end
      SVC: begin
        if (eret) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // a same-edge set beats both software and acknowledge clears
  assign pend_d = (pend_q & ~clr_v & ~ack4[2:0]) | set_v;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      mask_q  <= '0;
      pend_q  <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      pend_q  <= pend_d;
      id_q    <= id_d;
    end
  end

  always_comb begin
    bus.rdata = '0;
    if (bus.sel) begin
      case (bus.addr[3:2])
        2'd0:    bus.rdata = {29'd0, mask_q};
        2'd1:    bus.rdata = {29'd0, pend_q};
        2'd2:    bus.rdata = {28'd0, id_q, state_q};
        default: bus.rdata = '0;
      endcase
    end
  end

  assign int_req = (state_q == REQ);
  assign int_id  = id_q;
  assign hwint   = {3'b000, masked};

  logic unused_bits;
  assign unused_bits = ^{bus.addr[31:4], bus.addr[1:0],
                         bus.wdata[31:3], ack4[3], keep4[3]};

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: expectations are queued with each stimulus
// and drained against the DUT right after the following clock edge.
module tb_irq_ctrl;

  localparam int K_REQ  = 0;
  localparam int K_ID   = 1;
  localparam int K_HW   = 2;
  localparam int K_MASK = 3;
  localparam int K_PEND = 4;
  localparam int K_STAT = 5;
  localparam int K_OFFC = 6;
  localparam int K_NSEL = 7;

  typedef struct {
    string       tag;
    int          kind;
    logic [31:0] val;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] irq_src;
  logic       int_req;
  logic [1:0] int_id;
  logic       int_ack;
  logic       eret;
  logic [5:0] hwint;

  int n_tests = 0;
  int n_fail  = 0;
  exp_t sb[$];

  irq_ctrl_if bus ();

  irq_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .irq_src (irq_src),
    .bus     (bus),
    .int_req (int_req),
    .int_id  (int_id),
    .int_ack (int_ack),
    .eret    (eret),
    .hwint   (hwint)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_v(input int kind, input string tag,
                          input logic [31:0] val);
    exp_t e;
    e.tag  = tag;
    e.kind = kind;
    e.val  = val;
    sb.push_back(e);
  endtask

  task automatic rd(input logic [3:0] off, output logic [31:0] v);
    bus.sel  = 1'b1;
    bus.we   = 1'b0;
    bus.addr = 32'h7F30 + {28'd0, off};
    #1;
    v = bus.rdata;
    bus.sel = 1'b0;
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] v;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      case (e.kind)
        K_REQ:  v = {31'd0, int_req};
        K_ID:   v = {30'd0, int_id};
        K_HW:   v = {26'd0, hwint};
        K_MASK: rd(4'h0, v);
        K_PEND: rd(4'h4, v);
        K_STAT: rd(4'h8, v);
        K_OFFC: rd(4'hC, v);
        default: begin
          bus.sel  = 1'b0;
          bus.addr = 32'h7F38;
          #1;
          v = bus.rdata;
        end
      endcase
      chk(e.tag, v, e.val);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [3:0] off, input logic [31:0] d);
    bus.sel   = 1'b1;
    bus.we    = 1'b1;
    bus.addr  = 32'h7F30 + {28'd0, off};
    bus.wdata = d;
    tick();
    bus.sel = 1'b0;
    bus.we  = 1'b0;
  endtask

  task automatic pulse(input logic [2:0] v);
    irq_src = v;
    tick();
    irq_src = 3'b000;
  endtask

  task automatic do_ack();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  task automatic do_eret();
    eret = 1'b1;
    tick();
    eret = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    reset     = 1'b1;
    irq_src   = 3'b000;
    int_ack   = 1'b0;
    eret      = 1'b0;
    bus.sel   = 1'b0;
    bus.we    = 1'b0;
    bus.addr  = '0;
    bus.wdata = '0;

    // reset state
    expect_v(K_REQ,  "rst_req",  0);
    expect_v(K_ID,   "rst_id",   0);
    expect_v(K_HW,   "rst_hw",   0);
    expect_v(K_MASK, "rst_mask", 0);
    expect_v(K_PEND, "rst_pend", 0);
    expect_v(K_STAT, "rst_stat", 0);
    tick(); tick();
    drain();
    reset = 1'b0;

    // single source, full mask
    expect_v(K_MASK, "mask7", 32'h7);
    expect_v(K_NSEL, "nosel_rd", 0);
    expect_v(K_OFFC, "offc_rd", 0);
    wr(4'h0, 32'hFFFF_FFFF);
    drain();
    expect_v(K_PEND, "p0_pend", 32'h1);
    expect_v(K_HW,   "p0_hw",   32'h1);
    expect_v(K_REQ,  "p0_req_early", 0);
    pulse(3'b001);
    drain();
    expect_v(K_REQ,  "p0_req",  1);
    expect_v(K_ID,   "p0_id",   0);
    expect_v(K_STAT, "p0_stat", 32'h1);
    tick();
    drain();
    expect_v(K_REQ,  "p0_ack_req",  0);
    expect_v(K_STAT, "p0_ack_stat", 32'h2);
    expect_v(K_PEND, "p0_ack_pend", 0);
    do_ack();
    drain();
    expect_v(K_STAT, "p0_eret_stat", 0);
    do_eret();
    drain();

    // two simultaneous sources, priority and second grant
    expect_v(K_PEND, "p12_pend", 32'h6);
    pulse(3'b110);
    drain();
    expect_v(K_REQ, "p12_req", 1);
    expect_v(K_ID,  "p12_id",  1);
    tick();
    drain();
    expect_v(K_PEND, "p12_ack_pend", 32'h4);
    expect_v(K_STAT, "p12_ack_stat", 32'h6);
    expect_v(K_REQ,  "p12_nonest",   0);
    do_ack();
    drain();
    expect_v(K_STAT, "p12_eret_stat", 32'h4);
    do_eret();
    drain();
    expect_v(K_REQ,  "p2_req",  1);
    expect_v(K_ID,   "p2_id",   2);
    expect_v(K_STAT, "p2_stat", 32'h9);
    tick();
    drain();
    expect_v(K_PEND, "p2_ack_pend", 0);
    do_ack();
    drain();
    expect_v(K_STAT, "p2_eret_stat", 32'h8);
    do_eret();
    drain();

    // masked-out source, then unmask
    wr(4'h0, 32'h0);
    expect_v(K_PEND, "m0_pend", 32'h1);
    expect_v(K_HW,   "m0_hw",   0);
    pulse(3'b001);
    drain();
    expect_v(K_REQ, "m0_req", 0);
    tick();
    drain();
    expect_v(K_HW,  "um_hw",  32'h1);
    expect_v(K_REQ, "um_req_early", 0);
    wr(4'h0, 32'h1);
    drain();
    expect_v(K_REQ, "um_req", 1);
    expect_v(K_ID,  "um_id",  0);
    tick();
    drain();

    // software withdraws the granted request
    expect_v(K_REQ,  "w1c_req",  0);
    expect_v(K_STAT, "w1c_stat", 0);
    expect_v(K_PEND, "w1c_pend", 0);
    wr(4'h4, 32'h1);
    drain();
    expect_v(K_REQ, "w1c_req2", 0);
    tick();
    drain();

    // set beats a same-cycle clear
    wr(4'h0, 32'h0);
    irq_src = 3'b001;
    expect_v(K_PEND, "setpri_pend", 32'h1);
    wr(4'h4, 32'h1);
    irq_src = 3'b000;
    drain();

    // source held high across a W1C clear
    irq_src = 3'b001;
    tick();
    wr(4'h4, 32'h7);
`ifdef IRQ_EDGE_EN
    expect_v(K_PEND, "hold_pend", 0);
`else
    expect_v(K_PEND, "hold_pend", 32'h1);
`endif
    drain();
`ifdef IRQ_EDGE_EN
    expect_v(K_PEND, "hold_pend2", 0);
`else
    expect_v(K_PEND, "hold_pend2", 32'h1);
`endif
    tick();
    drain();
    irq_src = 3'b000;
    tick();
    expect_v(K_PEND, "hold_clr", 0);
    wr(4'h4, 32'h7);
    drain();

    // mask drop withdraws; stray ack ignored
    wr(4'h0, 32'h2);
    pulse(3'b010);
    expect_v(K_REQ, "md_req", 1);
    expect_v(K_ID,  "md_id",  1);
    tick();
    drain();
    expect_v(K_REQ,  "md_drop_req",  0);
    expect_v(K_STAT, "md_drop_stat", 32'h4);
    wr(4'h0, 32'h0);
    drain();
    expect_v(K_STAT, "stray_ack_stat", 32'h4);
    expect_v(K_PEND, "stray_ack_pend", 32'h2);
    do_ack();
    drain();
    expect_v(K_STAT, "stray_eret_stat", 32'h4);
    do_eret();
    drain();

    // reset while in service with pending sources
    wr(4'h0, 32'h7);
    tick();
    expect_v(K_REQ, "svc_req", 1);
    drain();
    do_ack();
    expect_v(K_PEND, "svc_pend", 32'h6);
    expect_v(K_STAT, "svc_stat", 32'h6);
    expect_v(K_REQ,  "svc_req0", 0);
    expect_v(K_HW,   "svc_hw",   32'h6);
    pulse(3'b110);
    drain();
    expect_v(K_REQ,  "rst2_req",  0);
    expect_v(K_ID,   "rst2_id",   0);
    expect_v(K_HW,   "rst2_hw",   0);
    expect_v(K_STAT, "rst2_stat", 0);
    expect_v(K_PEND, "rst2_pend", 0);
    expect_v(K_MASK, "rst2_mask", 0);
    reset = 1'b1;
    tick();
    drain();
    reset = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
